// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch clocked by clk, advanced by rising edges of clk_usr.
// clk_usr is sampled as asynchronous data and turned into a 1-cycle tick.
module stopwatch_counter #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_MIN     = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_usr,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic       running,
    output logic       tick,
    output logic       wrap
);

    localparam logic [3:0] MAX_HI = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_LO = 4'(MAX_MIN % 10);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   tick_q;
    state_t                 state_q, state_d;
    logic [3:0]             sec_lo_q, sec_lo_d;
    logic [3:0]             sec_hi_q, sec_hi_d;
    logic [3:0]             min_lo_q, min_lo_d;
    logic [3:0]             min_hi_q, min_hi_d;
    logic                   wrap_q, wrap_d;
    logic                   running_q;
    logic                   inc;
    logic                   at_max;

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else if (stop && state_q == RUN) begin
            state_d = PAUSE;
        end else if (start && state_q != RUN) begin
            state_d = RUN;
        end
    end

    // Only ticks seen while already in RUN advance the count.
    assign inc    = tick_q && (state_q == RUN);
    assign at_max = (sec_lo_q == 4'd9) && (sec_hi_q == 4'd5) &&
                    (min_lo_q == MAX_LO) && (min_hi_q == MAX_HI);

    always_comb begin
        sec_lo_d = sec_lo_q;
        sec_hi_d = sec_hi_q;
        min_lo_d = min_lo_q;
        min_hi_d = min_hi_q;
        wrap_d   = 1'b0;
        if (clear) begin
            sec_lo_d = 4'd0;
            sec_hi_d = 4'd0;
            min_lo_d = 4'd0;
            min_hi_d = 4'd0;
        end else if (inc) begin
            if (at_max) begin
                sec_lo_d = 4'd0;
                sec_hi_d = 4'd0;
                min_lo_d = 4'd0;
                min_hi_d = 4'd0;
                wrap_d   = 1'b1;
            end else if (sec_lo_q != 4'd9) begin
                sec_lo_d = sec_lo_q + 4'd1;
            end else begin
                sec_lo_d = 4'd0;
                if (sec_hi_q != 4'd5) begin
                    sec_hi_d = sec_hi_q + 4'd1;
                end else begin
                    sec_hi_d = 4'd0;
                    if (min_lo_q != 4'd9) begin
                        min_lo_d = min_lo_q + 4'd1;
                    end else begin
                        min_lo_d = 4'd0;
                        min_hi_d = min_hi_q + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            tick_q    <= 1'b0;
            state_q   <= IDLE;
            sec_lo_q  <= 4'd0;
            sec_hi_q  <= 4'd0;
            min_lo_q  <= 4'd0;
            min_hi_q  <= 4'd0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], clk_usr};
            prev_q    <= sync_q[SYNC_STAGES-1];
            tick_q    <= sync_q[SYNC_STAGES-1] & ~prev_q;
            state_q   <= state_d;
            sec_lo_q  <= sec_lo_d;
            sec_hi_q  <= sec_hi_d;
            min_lo_q  <= min_lo_d;
            min_hi_q  <= min_hi_d;
            wrap_q    <= wrap_d;
            running_q <= (state_d == RUN);
        end
    end

    assign sec_lo  = sec_lo_q;
    assign sec_hi  = sec_hi_q;
    assign min_lo  = min_lo_q;
    assign min_hi  = min_hi_q;
    assign running = running_q;
    assign tick    = tick_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: default instance plus a MAX_MIN=1
// instance sharing all inputs for the wrap cases.
module tb_stopwatch_counter;

    logic clk = 1'b0;
    logic rst;
    logic clk_usr;
    logic start;
    logic stop;
    logic clear;

    logic [3:0] s_lo1, s_hi1, m_lo1, m_hi1;
    logic       run1, tick1, wrap1;
    logic [3:0] s_lo2, s_hi2, m_lo2, m_hi2;
    logic       run2, tick2, wrap2;

    int n_checks = 0;
    int n_fails  = 0;
    int wrap1_cnt = 0;
    int wrap2_cnt = 0;
    int first_tick;
    int second_tick;
    int tick_cnt;

    stopwatch_counter dut1 (
        .clk(clk), .rst(rst), .clk_usr(clk_usr),
        .start(start), .stop(stop), .clear(clear),
        .sec_lo(s_lo1), .sec_hi(s_hi1), .min_lo(m_lo1), .min_hi(m_hi1),
        .running(run1), .tick(tick1), .wrap(wrap1)
    );

    stopwatch_counter #(.SYNC_STAGES(2), .MAX_MIN(1)) dut2 (
        .clk(clk), .rst(rst), .clk_usr(clk_usr),
        .start(start), .stop(stop), .clear(clear),
        .sec_lo(s_lo2), .sec_hi(s_hi2), .min_lo(m_lo2), .min_hi(m_hi2),
        .running(run2), .tick(tick2), .wrap(wrap2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wrap1) wrap1_cnt++;
        if (wrap2) wrap2_cnt++;
    end

    function automatic logic [15:0] t1();
        return {m_hi1, m_lo1, s_hi1, s_lo1};
    endfunction

    function automatic logic [15:0] t2();
        return {m_hi2, m_lo2, s_hi2, s_lo2};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cmd(input logic s, input logic p, input logic c);
        start = s;
        stop  = p;
        clear = c;
        cyc(1);
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            clk_usr = 1'b1;
            cyc(2);
            clk_usr = 1'b0;
            cyc(2);
        end
        cyc(4);
    endtask

    initial begin
        rst = 1'b0;
        clk_usr = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        clear = 1'b0;
        #1;
        check("rst_digits", 32'(t1()), 32'h0000);
        check("rst_running", 32'(run1), 32'd0);
        check("rst_tick", 32'(tick1), 32'd0);
        check("rst_wrap", 32'(wrap1), 32'd0);
        cyc(2);
        rst = 1'b1;
        cyc(2);

        first_tick = -1;
        second_tick = -1;
        tick_cnt = 0;
        clk_usr = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (tick1) begin
                tick_cnt++;
                if (first_tick < 0) first_tick = i;
                else if (second_tick < 0) second_tick = i;
            end
            if (i % 8 == 0) clk_usr = ~clk_usr;
        end
        cyc(4);
        check("tick_first_latency", 32'(first_tick), 32'd3);
        check("tick_second", 32'(second_tick), 32'd19);
        check("tick_count_width", 32'(tick_cnt), 32'd3);
        check("idle_no_count", 32'(t1()), 32'h0000);

        cmd(1'b1, 1'b0, 1'b0);
        ticks(60);
        check("count_60", 32'(t1()), 32'h0100);
        check("count_running", 32'(run1), 32'd1);
        ticks(539);
        check("count_599", 32'(t1()), 32'h0959);
        ticks(1);
        check("count_600", 32'(t1()), 32'h1000);
        ticks(154);
        check("count_1234", 32'(t1()), 32'h1234);

        #2;
        rst = 1'b0;
        #1;
        check("async_rst_digits", 32'(t1()), 32'h0000);
        check("async_rst_running", 32'(run1), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc(2);

        cmd(1'b1, 1'b0, 1'b0);
        ticks(5);
        check("pause_5", 32'(t1()), 32'h0005);
        cmd(1'b0, 1'b1, 1'b0);
        cyc(2);
        check("pause_running", 32'(run1), 32'd0);
        ticks(10);
        check("pause_hold", 32'(t1()), 32'h0005);
        cmd(1'b1, 1'b0, 1'b0);
        ticks(3);
        check("resume_8", 32'(t1()), 32'h0008);
        check("resume_running", 32'(run1), 32'd1);

        clk_usr = 1'b1;
        cyc(3);
        check("stop_tick_seen", 32'(tick1), 32'd1);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        clk_usr = 1'b0;
        cyc(4);
        check("stop_tick_counted", 32'(t1()), 32'h0009);
        check("stop_tick_paused", 32'(run1), 32'd0);

        cmd(1'b0, 1'b0, 1'b1);
        check("clear_pause", 32'(t1()), 32'h0000);
        cmd(1'b1, 1'b0, 1'b0);
        ticks(7);
        check("prio_pre", 32'(t1()), 32'h0007);
        cmd(1'b1, 1'b1, 1'b1);
        cyc(2);
        check("prio_digits", 32'(t1()), 32'h0000);
        check("prio_running", 32'(run1), 32'd0);
        ticks(2);
        check("prio_idle_hold", 32'(t1()), 32'h0000);

        cmd(1'b1, 1'b0, 1'b0);
        ticks(119);
        check("wrap_pre_d2", 32'(t2()), 32'h0159);
        check("wrap_pre_d1", 32'(t1()), 32'h0159);
        wrap1_cnt = 0;
        wrap2_cnt = 0;
        ticks(1);
        check("wrap_digits_d2", 32'(t2()), 32'h0000);
        check("wrap_pulses_d2", 32'(wrap2_cnt), 32'd1);
        check("nowrap_digits_d1", 32'(t1()), 32'h0200);
        check("nowrap_pulses_d1", 32'(wrap1_cnt), 32'd0);

        ticks(119);
        check("clrtick_pre_d2", 32'(t2()), 32'h0159);
        wrap2_cnt = 0;
        clk_usr = 1'b1;
        cyc(3);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        clk_usr = 1'b0;
        cyc(4);
        check("clrtick_digits", 32'(t2()), 32'h0000);
        check("clrtick_wrap", 32'(wrap2_cnt), 32'd0);
        check("clrtick_running", 32'(run2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
